// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button debouncer.
// Optional feature macro: BTN_DEBOUNCE_AUTOREPEAT_EN (auto-repeat on held buttons).
package btn_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int REPEAT_DELAY_DEF    = 50000000;
    localparam int REPEAT_PERIOD_DEF   = 10000000;

    // Larger of two sizes, used to size the shared repeat counter
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state debounce FSM with a
// saturating stability counter, and optional auto-repeat of the press pulse.
// Optional feature macro: BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    // Counter value seen on the edge that makes the run DEBOUNCE_CYCLES long
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          s;
    btn_state_e    state;
    logic [CW-1:0] cnt;
    logic          rep_hit;

    assign s = sync[1];

    // Bring the asynchronous button level into the clk domain
    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], btn};
    end

    // Debounce FSM; outputs are registered here so nothing combinational reaches a port
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE_LO;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= rep_hit;
            fall <= 1'b0;
            case (state)
                STABLE_LO: if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        db    <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        state <= WAIT_HI;
                        cnt   <= CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        db    <= 1'b1;
                        rise  <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE_HI: if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        db    <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        state <= WAIT_LO;
                        cnt   <= CW'(1);
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        db    <= 1'b0;
                        fall  <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt;
    logic          rfirst;
    logic          staying;

    // A repeat may only fire on an edge that keeps the channel in STABLE_HI,
    // so a release seen on this edge cancels it.
    assign staying = (state == STABLE_HI) && s;
    assign rep_hit = staying && (rcnt == (rfirst ? DLY_LAST : PER_LAST));

    // Cycles since the press pulse (or last repeat); restarts whenever STABLE_HI is left
    always_ff @(posedge clk) begin
        if (reset || !staying) begin
            rcnt   <= '0;
            rfirst <= 1'b1;
        end else if (rep_hit) begin
            rcnt   <= '0;
            rfirst <= 1'b0;
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end
`else
    // No repeat logic is built; the repeat parameters only shape a constant-zero term
    assign rep_hit = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

endmodule

// File: rtl/btn_debounce.sv
// N_BTN-channel push-button debouncer with press/release pulses.
// Optional feature macro: BTN_DEBOUNCE_AUTOREPEAT_EN (held buttons re-pulse btn_rise).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[i]),
            .db    (btn_db[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed scenarios with literal expectations plus
// randomized bouncing stimulus checked every cycle against a run-length model.
module tb_btn_debounce;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 5;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_db, btn_rise, btn_fall;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    btn_debounce #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .btn_db   (btn_db),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the level each channel's logic sees lags btn by two edges; a
    // run of D consecutive seen values differing from the accepted level
    // flips it. Held-high age since acceptance drives the repeat schedule.
    bit m_s1[N], m_s2[N], m_db[N], m_rise[N], m_fall[N];
    int m_run[N], m_age[N];

    always @(posedge clk) begin
        bit seen, was_hi;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0;
                m_rise[i] = 0; m_fall[i] = 0; m_run[i] = 0; m_age[i] = 0;
            end else begin
                seen    = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = btn[i];
                m_rise[i] = 0;
                m_fall[i] = 0;
                was_hi = m_db[i] && (m_run[i] == 0);
                if (seen != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i]  = seen;
                        m_run[i] = 0;
                        if (seen) m_rise[i] = 1; else m_fall[i] = 1;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (AR && was_hi && m_db[i] && m_run[i] == 0) begin
                    m_age[i]++;
                    if (m_age[i] >= RD && (m_age[i] - RD) % RP == 0) m_rise[i] = 1;
                end else begin
                    m_age[i] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        logic [N-1:0] mdb, mr, mf;
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                mdb[i] = m_db[i]; mr[i] = m_rise[i]; mf[i] = m_fall[i];
            end
            chk("model_db", btn_db, mdb);
            chk("model_rise", btn_rise, mr);
            chk("model_fall", btn_fall, mf);
        end
    end

    // Literal expectations over a window of edges after a stimulus change;
    // at==0 means no change is expected inside the window.
    task automatic watch(input string nm, input int edges, input int at,
                         input logic [N-1:0] db0, input logic [N-1:0] db1,
                         input logic [N-1:0] rs, input logic [N-1:0] fl);
        for (int k = 1; k <= edges; k++) begin
            @(negedge clk);
            chk({nm, "_db"},   btn_db,   (at > 0 && k >= at) ? db1 : db0);
            chk({nm, "_rise"}, btn_rise, (k == at) ? rs : '0);
            chk({nm, "_fall"}, btn_fall, (k == at) ? fl : '0);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_db", btn_db, '0);
        chk("reset_rise", btn_rise, '0);
        chk("reset_fall", btn_fall, '0);
        reset = 1'b0;

        // Clean press and release on channel 0
        btn = 4'b0001;
        watch("press0", 8, 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
        btn = 4'b0000;
        watch("rel0", 8, 6, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

        // Bounce on channel 1: 3 high, 2 low, then held
        btn = 4'b0010;
        watch("bnc1_a", 3, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        btn = 4'b0000;
        watch("bnc1_b", 2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        btn = 4'b0010;
        watch("bnc1_c", 8, 6, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
        btn = 4'b0000;
        repeat (12) @(negedge clk);

        // Channel 2: press, 2-cycle low glitch ignored, then real release
        btn = 4'b0100;
        watch("press2", 8, 6, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
        btn = 4'b0000;
        watch("gl2_a", 2, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        btn = 4'b0100;
        watch("gl2_b", 8, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        btn = 4'b0000;
        watch("rel2", 8, 6, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        repeat (4) @(negedge clk);

        // All channels pressed on the same edge
        btn = 4'b1111;
        watch("simul", 8, 6, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
        btn = 4'b0000;
        repeat (12) @(negedge clk);

        // Reset while ch0 is accepted and ch3 is mid-debounce; both held through it
        btn = 4'b0001;
        repeat (8) @(negedge clk);
        btn = 4'b1001;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_db", btn_db, '0);
        chk("rstmid_rise", btn_rise, '0);
        chk("rstmid_fall", btn_fall, '0);
        reset = 1'b0;
        watch("postrst", 8, 6, 4'b0000, 4'b1001, 4'b1001, 4'b0000);
        btn = 4'b0000;
        repeat (12) @(negedge clk);

        // Hold channel 0 for 40 cycles: repeats at +20,+25,+30,+35 when enabled
        btn = 4'b0001;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            chk("repeat_rise", btn_rise,
                (k == 6 || (AR && (k == 26 || k == 31 || k == 36 || k == 41))) ? 4'b0001 : 4'b0000);
            if (k == 40) btn = 4'b0000;
        end

        // Random bouncing with occasional resets, checked by the model
        for (int seg = 0; seg < 16; seg++) begin
            int p;
            case (seg % 4)
                0: p = 1;
                1: p = 4;
                2: p = 20;
                default: p = 50;
            endcase
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 99) < p) btn[i] = ~btn[i];
                reset = ($urandom_range(0, 399) == 0);
            end
        end
        reset = 1'b0;
        btn   = '0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles before a level change is accepted; legal range 1..2^24.
REQ-003 SHALL have parameter REPEAT_DELAY, default 50000000: cycles of accepted hold before the first auto-repeat pulse; used only with BTN_DEBOUNCE_AUTOREPEAT_EN.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between later auto-repeat pulses; used only with BTN_DEBOUNCE_AUTOREPEAT_EN.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port btn, input, N_BTN: raw asynchronous, bouncing push-button levels; 1 = pressed.
REQ-008 SHALL have port btn_db, output, N_BTN: debounced level per channel.
REQ-009 SHALL have port btn_rise, output, N_BTN: one-cycle press pulse per channel, including auto-repeat pulses.
REQ-010 SHALL have port btn_fall, output, N_BTN: one-cycle release pulse per channel.
REQ-011 SHALL use one clock domain; the reset is synchronous and active-high, as fixed above.

Function
REQ-012 Each btn bit SHALL pass through a two-flop synchronizer. No other logic SHALL read raw btn.
REQ-013 Each channel SHALL run a four-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-014 In STABLE_LO, a synchronized 1 SHALL move the channel to WAIT_HI with its counter at 1.
- In WAIT_HI, a synchronized 0 SHALL return to STABLE_LO and clear the counter (glitch rejected).
- In WAIT_HI, the counter SHALL increment while the input stays 1.
REQ-015 When the counter equals DEBOUNCE_CYCLES while the input is still 1, the channel SHALL enter STABLE_HI and register btn_db=1 and btn_rise=1 on the same edge.
- WAIT_LO SHALL mirror this, driving btn_db=0 and btn_fall=1.
- With DEBOUNCE_CYCLES=1, acceptance SHALL occur on the first edge where the synchronized input differs.
REQ-016 Latency: btn_db SHALL change on edge DEBOUNCE_CYCLES+2, counting the first clk edge that samples the new btn level as edge 1.
REQ-017 A bounce shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no change on btn_db, btn_rise or btn_fall.
REQ-018 btn_rise and btn_fall SHALL be high for exactly one cycle per accepted event. They SHALL never be high together on the same channel.
REQ-019 Channels SHALL be fully independent. Simultaneous events on several channels SHALL each pulse in the same cycle.
REQ-020 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, SHALL saturate and never wrap, and SHALL be cleared on every state entry.
REQ-021 All outputs SHALL be driven directly from flops, with no combinational path from btn.

Reset
REQ-022 While reset=1, on each clk edge the design SHALL clear:
- synchronizer flops, FSM (to STABLE_LO), counters and repeat counters;
- btn_db, btn_rise and btn_fall (all to 0).
REQ-023 Reset SHALL take effect mid-debounce or mid-repeat with no trailing pulse afterwards.
REQ-024 A button held through reset deassertion SHALL be reported as a new press, with btn_rise at the REQ-016 latency after the first post-reset edge.

Configuration
REQ-025 With macro BTN_DEBOUNCE_AUTOREPEAT_EN defined, a channel in STABLE_HI SHALL pulse btn_rise:
- REPEAT_DELAY cycles after the accepted press pulse;
- then every REPEAT_PERIOD cycles while still in STABLE_HI.
- Leaving STABLE_HI SHALL cancel pending repeats immediately.
REQ-026 Without BTN_DEBOUNCE_AUTOREPEAT_EN, repeat counters SHALL not be synthesized. btn_rise SHALL pulse only on accepted press transitions, and REPEAT_DELAY/REPEAT_PERIOD SHALL be ignored.

Structure
REQ-027 A shared package btn_pkg SHALL hold:
- the FSM state enum type;
- the default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-028 The per-channel synchronizer, FSM, counter and repeat logic SHALL live in a sub-module btn_debounce_ch. btn_debounce SHALL instantiate it N_BTN times in a generate loop.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5 unless stated)
REQ-029 Clean press: btn[0] 0->1 and held -> btn_db[0] rises on the 6th edge; btn_rise[0] is high for exactly that one cycle; other channels stay 0.
REQ-030 Bounce: btn[1] high for 3 cycles, low for 2, then high and held -> no output during the bounce; btn_db[1]=1 six edges after the final rise; exactly one btn_rise[1].
REQ-031 Release: held btn[2] goes to 0 -> btn_db[2] falls on the 6th edge with one btn_fall[2] pulse; a 2-cycle low glitch instead produces nothing.
REQ-032 Simultaneous: btn=4'b1111 on one edge -> btn_rise=4'b1111 in a single cycle, six edges later.
REQ-033 Reset mid-operation: reset asserted during WAIT_HI of btn[3] -> all outputs 0 next edge; with btn[3] still held after reset, btn_rise[3] appears six edges after reset deasserts.
REQ-034 Auto-repeat (macro on): btn[0] held 40 cycles -> btn_rise[0] at accept, +20, +25, +30, +35, then no pulse after release; with the macro off -> a single btn_rise[0] only.
